fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control/decode path.
- Holds the architectural PC and issues one instruction-memory read per instruction.
- Presents the fetched word and its PC to the decode unit.
- Computes the next PC from the control unit's pc-op command (increment / JAL / branch / JALR).
- Non-pipelined: one outstanding fetch, one instruction in flight.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- o_im_req_valid  out  1  imem read request valid.
- i_im_req_ready  in  1  imem accepts request.
- o_im_req_addr  out  XLEN  imem read address (= PC).
- i_im_rsp_valid  in  1  imem read data valid.
- i_im_rsp_data  in  32  imem read data.
- o_du_inst_valid  out  1  instruction valid to decode.
- i_du_inst_ready  in  1  decode accepts instruction.
- o_du_inst_data  out  32  instruction word.
- o_du_inst_pc  out  XLEN  PC of instruction.
- o_du_inst_pc4  out  XLEN  PC+4 (link value for JAL/JALR).
- i_cu_pc_op_valid  in  1  next-PC command valid (instruction completed).
- i_cu_pc_op_data  in  3  next-PC select.
- i_du_imm  in  XLEN  sign-extended J/B immediate.
- i_eu_alu_res  in  XLEN  JALR target (rs1+imm).
- o_fu_misaligned  out  1  sticky misaligned-target trap flag.
- o_fu_retired  out  32  count of accepted pc-op commands.

Behaviour:
- Synchronous active-low reset; every register updates on posedge i_clk.
- Reset values:
  - state=REQ, PC=RESET_PC.
  - o_im_req_valid=0, o_du_inst_valid=0.
  - o_du_inst_data=32'h0000_0013 (NOP).
  - o_du_inst_pc=RESET_PC, o_du_inst_pc4=RESET_PC+4.
  - o_fu_misaligned=0, o_fu_retired=0.
- pc_op encoding: 3'd0 PcIncr, 3'd1 PcJAL, 3'd2 PcBranch, 3'd3 PcJALR; 3'd4-7 treated as PcIncr.
- Next PC, all modulo 2^XLEN (wrap, no flag):
  - PcIncr → PC+4.
  - PcJAL / PcBranch → PC+i_du_imm.
  - PcJALR → i_eu_alu_res & ~1.
- States:
  - REQ: o_im_req_valid=1, o_im_req_addr=PC. On i_im_req_ready → WAIT. Valid and addr stay stable until accepted.
  - WAIT: on i_im_rsp_valid, capture i_im_rsp_data into o_du_inst_data, PC into o_du_inst_pc, PC+4 into o_du_inst_pc4 → ISSUE. Unbounded wait.
  - ISSUE: o_du_inst_valid=1, data/pc held stable. On i_du_inst_ready → EXEC.
  - EXEC: on i_cu_pc_op_valid:
    - Compute next PC and increment o_fu_retired (wraps at 2^32).
    - If next[1:0]!=0 → TRAP; PC is not updated.
    - Otherwise PC<=next → REQ.
  - TRAP: all valids 0, o_fu_misaligned=1. Held until reset.
- Minimum latency, zero-wait handshakes: REQ→ISSUE is 2 cycles (REQ accepted, response one cycle later); next REQ begins the cycle after the pc op is accepted.
- Ignored inputs:
  - i_im_rsp_valid outside WAIT.
  - i_cu_pc_op_valid outside EXEC, and its data.
  - i_du_inst_ready outside ISSUE.
- Simultaneous events: a response arriving in the same cycle a request is accepted is not captured; the response must come at least one cycle after acceptance.
- Reset mid-operation:
  - Any state returns to REQ with PC=RESET_PC on the next edge.
  - Instruction memory shares i_rst_n, so no stale response survives reset.
- o_du_inst_valid and o_im_req_valid are never asserted in the same cycle.

Test Plan:
- Reset then zero-wait imem, decode always ready, four PcIncr ops → requests at 0x0, 0x4, 0x8, 0xC; o_du_inst_pc4 = 0x4, 0x8, 0xC, 0x10; o_fu_retired=4.
- At PC=0x10, PcJAL with imm=0xFFFF_FFF0 → next request addr 0x0. At PC=0x0, PcBranch imm=0x100 → addr 0x100.
- PcJALR with alu_res=0x0000_0203 → addr 0x202 is misaligned, so TRAP, o_fu_misaligned=1, no further requests. alu_res=0x201 → addr 0x200, normal.
- Backpressure: i_im_req_ready low 3 cycles, i_du_inst_ready low 2 cycles → o_im_req_addr and o_du_inst_data/pc stay stable throughout; exactly one fetch per instruction.
- Spurious inputs: i_im_rsp_valid=1 with data 0xDEAD_BEEF during EXEC, and i_cu_pc_op_valid during WAIT → no state change, o_du_inst_data unchanged.
- Reset asserted in WAIT and in TRAP → next cycle state REQ, o_im_req_addr=RESET_PC, o_fu_misaligned=0, o_fu_retired=0; PC=0xFFFF_FFFC with PcIncr → wraps to 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch stage: one imem read per instruction, hands the
// word to decode, then waits for the control unit's next-PC command.
module fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_im_req_valid,
    input  logic             i_im_req_ready,
    output logic [XLEN-1:0]  o_im_req_addr,
    input  logic             i_im_rsp_valid,
    input  logic [31:0]      i_im_rsp_data,
    output logic             o_du_inst_valid,
    input  logic             i_du_inst_ready,
    output logic [31:0]      o_du_inst_data,
    output logic [XLEN-1:0]  o_du_inst_pc,
    output logic [XLEN-1:0]  o_du_inst_pc4,
    input  logic             i_cu_pc_op_valid,
    input  logic [2:0]       i_cu_pc_op_data,
    input  logic [XLEN-1:0]  i_du_imm,
    input  logic [XLEN-1:0]  i_eu_alu_res,
    output logic             o_fu_misaligned,
    output logic [31:0]      o_fu_retired
);

    localparam int unsigned IW  = 32;
    localparam logic [IW-1:0] NOP = 32'h0000_0013;

    localparam logic [2:0] PC_JAL    = 3'd1;
    localparam logic [2:0] PC_BRANCH = 3'd2;
    localparam logic [2:0] PC_JALR   = 3'd3;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_EXEC,
        S_TRAP
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] next_pc_c;
    logic            req_valid_d;
    logic            inst_valid_d;
    logic [IW-1:0]   inst_data_d;
    logic [XLEN-1:0] inst_pc_d;
    logic [XLEN-1:0] inst_pc4_d;
    logic            misaligned_d;
    logic [31:0]     retired_d;

    assign o_im_req_addr = pc;

    // Next-PC selection; codes 4-7 fall through to sequential increment.
    always_comb begin
        next_pc_c = pc + XLEN'(4);
        case (i_cu_pc_op_data)
            PC_JAL, PC_BRANCH: next_pc_c = pc + i_du_imm;
            PC_JALR:           next_pc_c = i_eu_alu_res & ~XLEN'(1);
            default:           next_pc_c = pc + XLEN'(4);
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        req_valid_d  = o_im_req_valid;
        inst_valid_d = o_du_inst_valid;
        inst_data_d  = o_du_inst_data;
        inst_pc_d    = o_du_inst_pc;
        inst_pc4_d   = o_du_inst_pc4;
        misaligned_d = o_fu_misaligned;
        retired_d    = o_fu_retired;

        case (state)
            S_REQ: begin
                req_valid_d = 1'b1;
                // Handshake only counts once the request is actually visible.
                if (o_im_req_valid && i_im_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_im_rsp_valid) begin
                    inst_data_d  = i_im_rsp_data;
                    inst_pc_d    = pc;
                    inst_pc4_d   = pc + XLEN'(4);
                    inst_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_du_inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (i_cu_pc_op_valid) begin
                    retired_d = o_fu_retired + 32'd1;
                    if (next_pc_c[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                        state_d      = S_TRAP;
                    end else begin
                        pc_d        = next_pc_c;
                        req_valid_d = 1'b1;
                        state_d     = S_REQ;
                    end
                end
            end
            S_TRAP: begin
                req_valid_d  = 1'b0;
                inst_valid_d = 1'b0;
                misaligned_d = 1'b1;
            end
            default: begin
                req_valid_d  = 1'b0;
                inst_valid_d = 1'b0;
                state_d      = S_REQ;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= S_REQ;
            pc              <= RESET_PC;
            o_im_req_valid  <= 1'b0;
            o_du_inst_valid <= 1'b0;
            o_du_inst_data  <= NOP;
            o_du_inst_pc    <= RESET_PC;
            o_du_inst_pc4   <= RESET_PC + XLEN'(4);
            o_fu_misaligned <= 1'b0;
            o_fu_retired    <= 32'd0;
        end else begin
            state           <= state_d;
            pc              <= pc_d;
            o_im_req_valid  <= req_valid_d;
            o_du_inst_valid <= inst_valid_d;
            o_du_inst_data  <= inst_data_d;
            o_du_inst_pc    <= inst_pc_d;
            o_du_inst_pc4   <= inst_pc4_d;
            o_fu_misaligned <= misaligned_d;
            o_fu_retired    <= retired_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized instruction streams,
// checked against a per-instruction reference model of PC flow and retirement.
module tb_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_im_req_valid;
    logic        i_im_req_ready;
    logic [31:0] o_im_req_addr;
    logic        i_im_rsp_valid;
    logic [31:0] i_im_rsp_data;
    logic        o_du_inst_valid;
    logic        i_du_inst_ready;
    logic [31:0] o_du_inst_data;
    logic [31:0] o_du_inst_pc;
    logic [31:0] o_du_inst_pc4;
    logic        i_cu_pc_op_valid;
    logic [2:0]  i_cu_pc_op_data;
    logic [31:0] i_du_imm;
    logic [31:0] i_eu_alu_res;
    logic        o_fu_misaligned;
    logic [31:0] o_fu_retired;

    always #5 i_clk = ~i_clk;

    fetch_unit dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .o_im_req_valid   (o_im_req_valid),
        .i_im_req_ready   (i_im_req_ready),
        .o_im_req_addr    (o_im_req_addr),
        .i_im_rsp_valid   (i_im_rsp_valid),
        .i_im_rsp_data    (i_im_rsp_data),
        .o_du_inst_valid  (o_du_inst_valid),
        .i_du_inst_ready  (i_du_inst_ready),
        .o_du_inst_data   (o_du_inst_data),
        .o_du_inst_pc     (o_du_inst_pc),
        .o_du_inst_pc4    (o_du_inst_pc4),
        .i_cu_pc_op_valid (i_cu_pc_op_valid),
        .i_cu_pc_op_data  (i_cu_pc_op_data),
        .i_du_imm         (i_du_imm),
        .i_eu_alu_res     (i_eu_alu_res),
        .o_fu_misaligned  (o_fu_misaligned),
        .o_fu_retired     (o_fu_retired)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_retired;
    int          m_fetches = 0;
    int          fetches   = 0;

    always @(posedge i_clk) begin
        if (i_rst_n && o_im_req_valid && i_im_req_ready) fetches <= fetches + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] model_next(input logic [2:0] op, input logic [31:0] imm,
                                               input logic [31:0] alu);
        if (op == 3'd1 || op == 3'd2) return m_pc + imm;
        if (op == 3'd3)               return {alu[31:1], 1'b0};
        return m_pc + 32'd4;
    endfunction

    task automatic step();
        @(negedge i_clk);
        check_eq("excl", 32'(o_im_req_valid & o_du_inst_valid), 32'd0);
    endtask

    task automatic idle_inputs();
        i_im_req_ready   = 1'b0;
        i_im_rsp_valid   = 1'b0;
        i_im_rsp_data    = 32'h0;
        i_du_inst_ready  = 1'b0;
        i_cu_pc_op_valid = 1'b0;
        i_cu_pc_op_data  = 3'd0;
        i_du_imm         = 32'h0;
        i_eu_alu_res     = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        step();
        check_eq("rst_req_valid",  32'(o_im_req_valid), 32'd0);
        check_eq("rst_inst_valid", 32'(o_du_inst_valid), 32'd0);
        check_eq("rst_data",       o_du_inst_data, 32'h0000_0013);
        check_eq("rst_pc",         o_du_inst_pc, 32'h0);
        check_eq("rst_pc4",        o_du_inst_pc4, 32'h4);
        check_eq("rst_addr",       o_im_req_addr, 32'h0);
        check_eq("rst_misaligned", 32'(o_fu_misaligned), 32'd0);
        check_eq("rst_retired",    o_fu_retired, 32'd0);
        i_rst_n   = 1'b1;
        m_pc      = 32'h0;
        m_retired = 32'h0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!o_im_req_valid && n < 8) begin
            step();
            n++;
        end
        check_eq("req_valid", 32'(o_im_req_valid), 32'd1);
    endtask

    // One full instruction: request, response, decode handoff, pc-op.
    task automatic do_instr(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] alu,
                            input int rq, input int rd, input int dq, input int ed,
                            input bit spur, output bit trapped);
        logic [31:0] nxt;
        trapped = 1'b0;
        wait_req();
        check_eq("req_addr", o_im_req_addr, m_pc);
        for (int i = 0; i < rq; i++) begin
            i_im_rsp_valid = spur;
            i_im_rsp_data  = 32'hDEAD_BEEF;
            step();
            check_eq("req_hold_valid", 32'(o_im_req_valid), 32'd1);
            check_eq("req_hold_addr", o_im_req_addr, m_pc);
        end
        i_im_req_ready = 1'b1;
        i_im_rsp_valid = spur;
        i_im_rsp_data  = 32'hDEAD_BEEF;
        step();
        m_fetches++;
        i_im_req_ready = 1'b0;
        i_im_rsp_valid = 1'b0;
        check_eq("req_drop", 32'(o_im_req_valid), 32'd0);
        for (int i = 0; i < rd; i++) begin
            i_cu_pc_op_valid = spur;
            i_cu_pc_op_data  = 3'($urandom_range(0, 7));
            step();
            check_eq("wait_no_inst", 32'(o_du_inst_valid), 32'd0);
            check_eq("wait_retired", o_fu_retired, m_retired);
        end
        i_cu_pc_op_valid = 1'b0;
        i_im_rsp_valid   = 1'b1;
        i_im_rsp_data    = mem_word(m_pc);
        step();
        i_im_rsp_valid = 1'b0;
        i_im_rsp_data  = 32'hDEAD_BEEF;
        check_eq("inst_valid", 32'(o_du_inst_valid), 32'd1);
        check_eq("inst_data",  o_du_inst_data, mem_word(m_pc));
        check_eq("inst_pc",    o_du_inst_pc, m_pc);
        check_eq("inst_pc4",   o_du_inst_pc4, m_pc + 32'd4);
        for (int i = 0; i < dq; i++) begin
            step();
            check_eq("issue_hold_valid", 32'(o_du_inst_valid), 32'd1);
            check_eq("issue_hold_data", o_du_inst_data, mem_word(m_pc));
            check_eq("issue_hold_pc", o_du_inst_pc, m_pc);
        end
        i_du_inst_ready = 1'b1;
        step();
        i_du_inst_ready = 1'b0;
        check_eq("exec_no_inst", 32'(o_du_inst_valid), 32'd0);
        for (int i = 0; i < ed; i++) begin
            i_im_rsp_valid = spur;
            i_im_rsp_data  = 32'hDEAD_BEEF;
            step();
            check_eq("exec_data", o_du_inst_data, mem_word(m_pc));
            check_eq("exec_no_req", 32'(o_im_req_valid), 32'd0);
        end
        i_im_rsp_valid   = 1'b0;
        nxt              = model_next(op, imm, alu);
        i_cu_pc_op_valid = 1'b1;
        i_cu_pc_op_data  = op;
        i_du_imm         = imm;
        i_eu_alu_res     = alu;
        step();
        i_cu_pc_op_valid = 1'b0;
        m_retired        = m_retired + 32'd1;
        check_eq("retired", o_fu_retired, m_retired);
        if (nxt[1:0] != 2'b00) begin
            trapped = 1'b1;
            for (int i = 0; i < 3; i++) begin
                check_eq("trap_flag", 32'(o_fu_misaligned), 32'd1);
                check_eq("trap_req", 32'(o_im_req_valid), 32'd0);
                check_eq("trap_inst", 32'(o_du_inst_valid), 32'd0);
                i_im_req_ready = 1'b1;
                step();
            end
            i_im_req_ready = 1'b0;
        end else begin
            m_pc = nxt;
            check_eq("no_trap", 32'(o_fu_misaligned), 32'd0);
            check_eq("req_latency", 32'(o_im_req_valid), 32'd1);
            check_eq("next_addr", o_im_req_addr, m_pc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bit          tr;
        logic [2:0]  op;
        logic [31:0] imm;
        logic [31:0] alu;

        i_rst_n = 1'b0;
        idle_inputs();
        do_reset();

        // Sequential run, zero-wait handshakes.
        for (int i = 0; i < 4; i++) do_instr(3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1'b0, tr);
        check_eq("retired4", o_fu_retired, 32'd4);
        check_eq("pc_at_10", o_im_req_addr, 32'h10);

        do_instr(3'd1, 32'hFFFF_FFF0, 32'h0, 0, 0, 0, 0, 1'b0, tr);
        check_eq("jal_back", o_im_req_addr, 32'h0);
        do_instr(3'd2, 32'h0000_0100, 32'h0, 0, 0, 0, 0, 1'b0, tr);
        check_eq("branch", o_im_req_addr, 32'h100);
        do_instr(3'd3, 32'h0, 32'h0000_0201, 0, 0, 0, 0, 1'b0, tr);
        check_eq("jalr_ok", o_im_req_addr, 32'h200);
        do_instr(3'd3, 32'h0, 32'h0000_0203, 0, 0, 0, 0, 1'b0, tr);
        check_eq("jalr_trap", 32'(tr), 32'd1);
        do_reset();

        // Backpressure on both sides plus spurious inputs.
        do_instr(3'd0, 32'h0, 32'h0, 3, 2, 2, 2, 1'b1, tr);
        check_eq("bp_pc", o_im_req_addr, 32'h4);

        // Reset while waiting for the imem response.
        wait_req();
        i_im_req_ready = 1'b1;
        step();
        m_fetches++;
        i_im_req_ready = 1'b0;
        do_reset();

        // Wrap from the top of the address space.
        do_instr(3'd1, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 1'b0, tr);
        check_eq("top_pc", o_im_req_addr, 32'hFFFF_FFFC);
        do_instr(3'd0, 32'h0, 32'h0, 0, 1, 0, 0, 1'b0, tr);
        check_eq("wrap_pc", o_im_req_addr, 32'h0);

        for (int k = 0; k < 60; k++) begin
            op  = 3'($urandom_range(0, 7));
            imm = $urandom;
            alu = $urandom;
            if ($urandom_range(0, 9) != 0) imm[1:0] = 2'b00;
            if ($urandom_range(0, 4) != 0) alu[1] = 1'b0;
            do_instr(op, imm, alu, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), tr);
            if (tr) do_reset();
        end

        step();
        check_eq("fetch_count", 32'(fetches), 32'(m_fetches));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
